// File: rtl/unit_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pack
// Shared definitions for the unit bus arbiter: requester/slave counts, the
// bus widths, the sequencer state type and the address decode helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package arb_pack;

    localparam int NUM_REQ = 4;
    localparam int NUM_SLV = 6;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 2;
    localparam int SLV_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // The slave is selected by the top three address bits.
    function automatic logic [SLV_W-1:0] slave_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: SLV_W];
    endfunction

    // Slave indices 6 and 7 have no slave behind them.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return slave_index(addr) < SLV_W'(NUM_SLV);
    endfunction

    // One-hot slave select for a (valid) slave index.
    function automatic logic [NUM_SLV-1:0] slave_select(input logic [SLV_W-1:0] idx);
        return NUM_SLV'(1) << idx;
    endfunction

endpackage

// File: rtl/unit_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// unit_bus_arbiter_if
// Bundles the requester-side handshake and the decoded slave bus of the unit
// bus arbiter.
//   Requester side : req_in, req_wr_rd_in, req_addr_in, req_wr_data_in (in)
//                    grant_out, done_out, err_out, rd_data_out          (out)
//   Slave side     : sel_en_out, wr_rd_d_out, addr_out, wr_data_out     (out)
//                    rd_data_in, ack_in                                 (in)
// Modport master is the arbiter's view; modport slave is the view of the
// surrounding logic (requesters plus slaves) that drives the inputs.
// ---------------------------------------------------------------------------
interface unit_bus_arbiter_if
    import arb_pack::*;
();

    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ-1:0]        req_wr_rd_in;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ*DATA_W-1:0] req_wr_data_in;

    logic [NUM_REQ-1:0]        grant_out;
    logic [NUM_REQ-1:0]        done_out;
    logic                      err_out;
    logic [DATA_W-1:0]         rd_data_out;

    logic [NUM_SLV-1:0]        sel_en_out;
    logic                      wr_rd_d_out;
    logic [ADDR_W-1:0]         addr_out;
    logic [DATA_W-1:0]         wr_data_out;
    logic [DATA_W-1:0]         rd_data_in;
    logic [NUM_SLV-1:0]        ack_in;

    modport master (
        input  req_in, req_wr_rd_in, req_addr_in, req_wr_data_in,
        input  rd_data_in, ack_in,
        output grant_out, done_out, err_out, rd_data_out,
        output sel_en_out, wr_rd_d_out, addr_out, wr_data_out
    );

    modport slave (
        output req_in, req_wr_rd_in, req_addr_in, req_wr_data_in,
        output rd_data_in, ack_in,
        input  grant_out, done_out, err_out, rd_data_out,
        input  sel_en_out, wr_rd_d_out, addr_out, wr_data_out
    );

endinterface

// File: rtl/unit_bus_arbiter_rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin pick among NUM_REQ requesters. The search starts
// at last_grant+1 (mod NUM_REQ) so the most recent owner has lowest priority.
//   req        in   request vector
//   last_grant in   index of the previous owner
//   grant      out  one-hot winner (all zero when nothing is requested)
//   index      out  binary index of the winner (0 when nothing is requested)
// ---------------------------------------------------------------------------
module rr_priority_picker
    import arb_pack::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // Two-bit addition wraps naturally over the four requesters.
            cand = last_grant + IDX_W'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/unit_bus_arbiter.sv
// ---------------------------------------------------------------------------
// unit_bus_arbiter
// Round-robin arbiter and single-outstanding transaction sequencer sharing a
// six-slave decoded bus between four requesters. The winner's payload is
// captured at the grant edge, the decoded slave is selected until it acks or
// the access times out, and the result is returned to the owner as a
// one-cycle done pulse qualified by err_out.
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset; abandons any transaction
//   bus    master modport of unit_bus_arbiter_if (requester and slave sides)
// Parameter TIMEOUT: ACCESS cycles allowed without ack (2..255).
// ---------------------------------------------------------------------------
module unit_bus_arbiter
    import arb_pack::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    unit_bus_arbiter_if.master bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t          state, state_next;
    logic [IDX_W-1:0]    last_grant, last_grant_next;
    logic [IDX_W-1:0]    owner, owner_next;
    logic [CNT_W-1:0]    cnt, cnt_next;

    logic [NUM_REQ-1:0]  grant, grant_next;
    logic [NUM_REQ-1:0]  done, done_next;
    logic                err, err_next;
    logic [DATA_W-1:0]   rd_data, rd_data_next;
    logic [NUM_SLV-1:0]  sel_en, sel_en_next;
    logic                wr_rd, wr_rd_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic [DATA_W-1:0]   wr_data, wr_data_next;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wr_data;
    logic                pick_wr_rd;
    logic                ack_hit;

    rr_priority_picker u_picker (
        .req        (bus.req_in),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .index      (pick_idx)
    );

    // Payload of the requester that would win this cycle.
    assign pick_addr    = bus.req_addr_in[{pick_idx, 3'b000} +: ADDR_W];
    assign pick_wr_data = bus.req_wr_data_in[{pick_idx, 3'b000} +: DATA_W];
    assign pick_wr_rd   = bus.req_wr_rd_in[pick_idx];

    // Only the ack of the currently selected slave counts.
    assign ack_hit = |(sel_en & bus.ack_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        owner_next      = owner;
        cnt_next        = cnt;
        grant_next      = grant;
        done_next       = '0;
        err_next        = err;
        rd_data_next    = rd_data;
        sel_en_next     = sel_en;
        wr_rd_next      = wr_rd;
        addr_next       = addr;
        wr_data_next    = wr_data;

        case (state)
            IDLE: begin
                // The done cycle of the previous transaction lives here; the
                // next edge retires it and may start a new one.
                grant_next   = '0;
                err_next     = 1'b0;
                rd_data_next = '0;
                sel_en_next  = '0;
                if (|bus.req_in) begin
                    grant_next   = pick_grant;
                    owner_next   = pick_idx;
                    addr_next    = pick_addr;
                    wr_data_next = pick_wr_data;
                    wr_rd_next   = pick_wr_rd;
                    if (addr_valid(pick_addr)) begin
                        sel_en_next = slave_select(slave_index(pick_addr));
                        cnt_next    = '0;
                        state_next  = ACCESS;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end
                end
            end

            ACCESS: begin
                // Ack is tested first so it wins over a simultaneous timeout.
                if (ack_hit) begin
                    sel_en_next  = '0;
                    err_next     = 1'b0;
                    rd_data_next = wr_rd ? '0 : bus.rd_data_in;
                    state_next   = RESP;
                end else if (cnt == CNT_LAST) begin
                    sel_en_next  = '0;
                    err_next     = 1'b1;
                    rd_data_next = '0;
                    state_next   = RESP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            RESP: begin
                done_next       = grant;
                last_grant_next = owner;
                state_next      = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            cnt        <= '0;
            grant      <= '0;
            done       <= '0;
            err        <= 1'b0;
            rd_data    <= '0;
            sel_en     <= '0;
            wr_rd      <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
        end else begin
            last_grant <= last_grant_next;
            owner      <= owner_next;
            cnt        <= cnt_next;
            grant      <= grant_next;
            done       <= done_next;
            err        <= err_next;
            rd_data    <= rd_data_next;
            sel_en     <= sel_en_next;
            wr_rd      <= wr_rd_next;
            addr       <= addr_next;
            wr_data    <= wr_data_next;
        end
    end

    assign bus.grant_out   = grant;
    assign bus.done_out    = done;
    assign bus.err_out     = err;
    assign bus.rd_data_out = rd_data;
    assign bus.sel_en_out  = sel_en;
    assign bus.wr_rd_d_out = wr_rd;
    assign bus.addr_out    = addr;
    assign bus.wr_data_out = wr_data;

endmodule
